// File: rtl/sp_dp_group.sv
// sp_dp_group: one A vector against N_UNIT B vectors with 2:4 sparse operand select and K-tile accumulation.
// Define SP_DP_SATURATE_EN for a saturating accumulator; the default build wraps in DW_ADD.
module sp_dp_group #(
    parameter int N_UNIT = 4,
    parameter int N_MUL  = 4,
    parameter int DW_MUL = 8,
    parameter int DW_ADD = 32,
    parameter int CNT_W  = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             mode,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_last,
    input  logic [N_MUL*DW_MUL-1:0]          in_a,
    input  logic [N_MUL*2-1:0]               in_meta,
    input  logic [N_UNIT*2*N_MUL*DW_MUL-1:0] in_b,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [N_UNIT*DW_ADD-1:0]         out,
    output logic [CNT_W-1:0]                 out_beats,
    output logic                             meta_err
);
    localparam int NB = 2 * N_MUL;
    localparam int PW = 2 * DW_MUL;

    logic stall, accept, bad_meta;
    logic p1_valid_q, p1_last_q, p2_valid_q, p2_last_q;
    logic acc_first_q, out_valid_q, meta_err_q;
    logic signed [PW-1:0]     prod_d [N_UNIT][N_MUL];
    logic signed [PW-1:0]     prod_q [N_UNIT][N_MUL];
    logic signed [DW_ADD-1:0] sum_d  [N_UNIT];
    logic signed [DW_ADD-1:0] sum_q  [N_UNIT];
    logic signed [DW_ADD-1:0] acc_d  [N_UNIT];
    logic signed [DW_ADD-1:0] acc_q  [N_UNIT];
    logic [N_UNIT*DW_ADD-1:0] out_d, out_q;
    logic [CNT_W-1:0]         cnt_d, cnt_q, out_beats_q;

    function automatic logic signed [PW-1:0] mul(input logic signed [DW_MUL-1:0] x,
                                                 input logic signed [DW_MUL-1:0] y);
        logic signed [PW-1:0] xe, ye;
        xe = x;
        ye = y;
        return xe * ye;
    endfunction

    function automatic logic signed [DW_ADD-1:0] acc_add(input logic signed [DW_ADD-1:0] x,
                                                         input logic signed [DW_ADD-1:0] y);
`ifdef SP_DP_SATURATE_EN
        logic signed [DW_ADD:0] s;
        s = {x[DW_ADD-1], x} + {y[DW_ADD-1], y};
        return (s[DW_ADD] != s[DW_ADD-1]) ?
               (s[DW_ADD] ? {1'b1, {(DW_ADD-1){1'b0}}} : {1'b0, {(DW_ADD-1){1'b1}}}) :
               s[DW_ADD-1:0];
`else
        return x + y;
`endif
    endfunction

    // Only a held last beat in P2 against an unconsumed result can block the pipe.
    assign stall    = !enable || (out_valid_q && !out_ready && p2_valid_q && p2_last_q);
    assign in_ready = !stall;
    assign accept   = in_valid && !stall;

    // Sparse: A element j holds the nonzero at position meta[j] of group j/2.
    always_comb begin
        int sel;
        sel = 0;
        for (int u = 0; u < N_UNIT; u++) begin
            for (int j = 0; j < N_MUL; j++) begin
                sel = mode ? 4 * (j / 2) + int'(in_meta[2*j +: 2]) : j;
                prod_d[u][j] = mul(in_a[j*DW_MUL +: DW_MUL], in_b[(u*NB + sel)*DW_MUL +: DW_MUL]);
            end
        end
    end

    always_comb begin
        bad_meta = 1'b0;
        for (int k = 0; k < N_MUL / 2; k++)
            bad_meta = bad_meta | (in_meta[4*k +: 2] >= in_meta[4*k+2 +: 2]);
    end

    always_comb begin
        for (int u = 0; u < N_UNIT; u++) begin
            sum_d[u] = '0;
            for (int j = 0; j < N_MUL; j++)
                sum_d[u] = sum_d[u] + {{(DW_ADD-PW){prod_q[u][j][PW-1]}}, prod_q[u][j]};
        end
    end

    always_comb begin
        out_d = '0;
        for (int u = 0; u < N_UNIT; u++) begin
            acc_d[u] = acc_first_q ? sum_q[u] : acc_add(acc_q[u], sum_q[u]);
            out_d[u*DW_ADD +: DW_ADD] = acc_d[u];
        end
        cnt_d = acc_first_q ? CNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + 1'b1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1_valid_q  <= 1'b0;
            p1_last_q   <= 1'b0;
            p2_valid_q  <= 1'b0;
            p2_last_q   <= 1'b0;
            prod_q      <= '{default: '0};
            sum_q       <= '{default: '0};
            acc_q       <= '{default: '0};
            cnt_q       <= '0;
            acc_first_q <= 1'b1;
            out_q       <= '0;
            out_beats_q <= '0;
            out_valid_q <= 1'b0;
            meta_err_q  <= 1'b0;
        end else if (!stall) begin
            p1_valid_q <= accept;
            p1_last_q  <= in_last;
            prod_q     <= prod_d;
            p2_valid_q <= p1_valid_q;
            p2_last_q  <= p1_last_q;
            sum_q      <= sum_d;
            if (p2_valid_q) begin
                acc_q       <= acc_d;
                cnt_q       <= cnt_d;
                acc_first_q <= p2_last_q;
            end
            if (p2_valid_q && p2_last_q) begin
                out_q       <= out_d;
                out_beats_q <= cnt_d;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept && mode && bad_meta)
                meta_err_q <= 1'b1;
        end
    end

    assign out       = out_q;
    assign out_beats = out_beats_q;
    assign out_valid = out_valid_q;
    assign meta_err  = meta_err_q;
endmodule

// File: tb/tb_sp_dp_group.sv
// tb_sp_dp_group: scoreboard bench for sp_dp_group; results are modelled at accept and checked at handshake.
module tb_sp_dp_group;
    localparam int N_UNIT = 4, N_MUL = 4, DW_MUL = 8, DW_ADD = 32, CNT_W = 8;
    localparam int AW = N_MUL * DW_MUL;
    localparam int BW = N_UNIT * 2 * N_MUL * DW_MUL;
    localparam int OW = N_UNIT * DW_ADD;

    logic clk = 1'b0, reset = 1'b0, enable = 1'b1, mode = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, meta_err;
    logic [AW-1:0] in_a = '0;
    logic [2*N_MUL-1:0] in_meta = '0;
    logic [BW-1:0] in_b = '0;
    logic [OW-1:0] out;
    logic [CNT_W-1:0] out_beats;

    typedef struct packed {
        logic [OW-1:0]    v;
        logic [CNT_W-1:0] beats;
    } res_t;

    res_t exp_q[$];
    int errors = 0, checks = 0;
    int cyc = 0, last_pop = -10, run = 0, run_max = 0;
    logic accepted = 1'b0;
    logic signed [DW_ADD-1:0] m_acc [N_UNIT];
    logic [CNT_W-1:0] m_cnt = '0;
    logic m_first = 1'b1, m_err = 1'b0;

    always #5 clk = ~clk;

    sp_dp_group dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_a(in_a), .in_meta(in_meta), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .out_beats(out_beats), .meta_err(meta_err)
    );

    function automatic logic [AW-1:0] pack_a(input int a0, input int a1, input int a2, input int a3);
        return {DW_MUL'(a3), DW_MUL'(a2), DW_MUL'(a1), DW_MUL'(a0)};
    endfunction

    function automatic logic [BW-1:0] put_b(input logic [BW-1:0] b, input int u, input int k, input int v);
        b[(u*2*N_MUL + k)*DW_MUL +: DW_MUL] = DW_MUL'(v);
        return b;
    endfunction

    function automatic int beat_sum(input int u, input logic md, input logic [AW-1:0] a,
                                    input logic [2*N_MUL-1:0] mt, input logic [BW-1:0] b);
        int s, k;
        logic signed [DW_MUL-1:0] av, bv;
        s = 0;
        for (int j = 0; j < N_MUL; j++) begin
            k = md ? 4 * (j / 2) + int'(mt[2*j +: 2]) : j;
            av = a[j*DW_MUL +: DW_MUL];
            bv = b[(u*2*N_MUL + k)*DW_MUL +: DW_MUL];
            s += int'(av) * int'(bv);
        end
        return s;
    endfunction

    function automatic logic signed [DW_ADD-1:0] madd(input logic signed [DW_ADD-1:0] x,
                                                      input logic signed [DW_ADD-1:0] y);
`ifdef SP_DP_SATURATE_EN
        longint s;
        s = longint'(x) + longint'(y);
        if (s > 64'sd2147483647) return 32'h7FFFFFFF;
        if (s < -64'sd2147483648) return 32'h80000000;
        return s[31:0];
`else
        return x + y;
`endif
    endfunction

    // One clock: sample at negedge, consume a result on handshake, return at posedge+1.
    task automatic tick();
        res_t r;
        @(negedge clk);
        accepted = in_valid && in_ready;
        cyc++;
        if (reset && enable && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got out=%h beats=%0d, required no pending result", out, out_beats);
            end else begin
                r = exp_q.pop_front();
                if ({out, out_beats} !== r) begin
                    errors++;
                    $display("FAIL sb_result: got out=%h beats=%0d, required out=%h beats=%0d",
                             out, out_beats, r.v, r.beats);
                end
            end
            run = (last_pop == cyc - 1) ? run + 1 : 1;
            last_pop = cyc;
            if (run > run_max) run_max = run;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic md, input logic lst, input logic [AW-1:0] a,
                             input logic [2*N_MUL-1:0] mt, input logic [BW-1:0] b);
        int n;
        logic [OW-1:0] pk;
        mode = md; in_last = lst; in_a = a; in_meta = mt; in_b = b; in_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!accepted && n < 100);
        in_valid = 1'b0;
        checks++;
        if (!accepted) begin
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required accept", n);
        end else begin
            pk = '0;
            for (int u = 0; u < N_UNIT; u++) begin
                m_acc[u] = m_first ? beat_sum(u, md, a, mt, b) : madd(m_acc[u], beat_sum(u, md, a, mt, b));
                pk[u*DW_ADD +: DW_ADD] = m_acc[u];
            end
            m_cnt = m_first ? CNT_W'(1) : ((m_cnt == '1) ? m_cnt : m_cnt + CNT_W'(1));
            if (md)
                for (int k = 0; k < N_MUL / 2; k++)
                    if (mt[4*k +: 2] >= mt[4*k+2 +: 2]) m_err = 1'b1;
            if (lst) exp_q.push_back(res_t'({pk, m_cnt}));
            m_first = lst;
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic drain();
        repeat (8) tick();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL drain: %0d results still pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (out !== '0) begin errors++; $display("FAIL reset_out: got %h, required 0", out); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        checks++;
        if (out_beats !== '0) begin errors++; $display("FAIL reset_out_beats: got %0d, required 0", out_beats); end
        checks++;
        if (meta_err !== 1'b0) begin errors++; $display("FAIL reset_meta_err: got %b, required 0", meta_err); end
        reset = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b, required 1", in_ready); end
    endtask

    task automatic test_dense();
        logic [BW-1:0] b;
        b = '0;
        for (int k = 0; k < 4; k++) b = put_b(b, 0, k, 1);
        b = put_b(b, 1, 0, -1);
        b = put_b(b, 1, 3, 2);
        b = put_b(b, 2, 1, 3);
        b = put_b(b, 3, 5, 9);
        send_beat(1'b0, 1'b1, pack_a(1, 2, 3, 4), 8'hFF, b);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL dense_early: out_valid=%b, required 0", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL dense_latency: out_valid=%b, required 1", out_valid); end
        checks++;
        if (out !== {32'd0, 32'd6, 32'd7, 32'd10})
            begin errors++; $display("FAIL dense_value: got %h, required 0/6/7/10", out); end
        checks++;
        if (out_beats !== 8'd1) begin errors++; $display("FAIL dense_beats: got %0d, required 1", out_beats); end
        checks++;
        if (meta_err !== 1'b0) begin errors++; $display("FAIL dense_meta_err: got %b, required 0", meta_err); end
        drain();
    endtask

    task automatic test_sparse();
        logic [BW-1:0] b;
        b = '0;
        for (int u = 0; u < N_UNIT; u++)
            for (int k = 0; k < 2 * N_MUL; k++) b = put_b(b, u, k, k + u);
        send_beat(1'b1, 1'b0, pack_a(5, -3, 2, 7), 8'h9C, b);
        send_beat(1'b1, 1'b1, pack_a(5, -3, 2, 7), 8'h9C, b);
        wait_valid();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL sparse_valid: got %b, required 1", out_valid); end
        checks++;
        if (out[31:0] !== 32'd86) begin errors++; $display("FAIL sparse_out0: got %0d, required 86", $signed(out[31:0])); end
        checks++;
        if (out[63:32] !== 32'd108) begin errors++; $display("FAIL sparse_out1: got %0d, required 108", $signed(out[63:32])); end
        checks++;
        if (out_beats !== 8'd2) begin errors++; $display("FAIL sparse_beats: got %0d, required 2", out_beats); end
        checks++;
        if (meta_err !== 1'b0) begin errors++; $display("FAIL sparse_meta_err: got %b, required 0", meta_err); end
        drain();
    endtask

    task automatic test_bad_meta();
        logic [BW-1:0] b;
        b = '0;
        for (int k = 0; k < 2 * N_MUL; k++) b = put_b(b, 0, k, k);
        send_beat(1'b1, 1'b1, pack_a(1, 1, 1, 1), 8'h4A, b);
        checks++;
        if (meta_err !== m_err) begin errors++; $display("FAIL bad_meta_set: got %b, required %b", meta_err, m_err); end
        wait_valid();
        checks++;
        if (out[31:0] !== 32'd13) begin errors++; $display("FAIL bad_meta_out0: got %0d, required 13", $signed(out[31:0])); end
        drain();
        send_beat(1'b0, 1'b1, pack_a(1, 1, 1, 1), 8'h00, b);
        drain();
        checks++;
        if (meta_err !== 1'b1) begin errors++; $display("FAIL bad_meta_sticky: got %b, required 1", meta_err); end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] b;
        b = '0;
        for (int k = 0; k < 4; k++) b = put_b(b, 0, k, 1);
        out_ready = 1'b0;
        for (int t = 0; t < 3; t++) send_beat(1'b0, 1'b1, pack_a(t + 1, 2, 3, 4), '0, b);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
            checks++;
            if (out_valid !== 1'b1 || out[31:0] !== 32'd10)
                begin errors++; $display("FAIL bp_hold: valid=%b out0=%0d, required 1/10", out_valid, out[31:0]); end
            tick();
        end
        out_ready = 1'b1;
        drain();
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] b;
        b = '0;
        for (int k = 0; k < 4; k++) b = put_b(b, 0, k, 1);
        run_max = 0;
        for (int i = 0; i < 6; i++) send_beat(1'b0, 1'b1, pack_a(i + 1, 1, 1, 1), '0, b);
        drain();
        checks++;
        if (run_max !== 6) begin errors++; $display("FAIL b2b_rate: longest run %0d, required 6", run_max); end
    endtask

    task automatic test_enable_freeze();
        logic [BW-1:0] b;
        b = '0;
        for (int k = 0; k < 4; k++) b = put_b(b, 0, k, 1);
        send_beat(1'b0, 1'b1, pack_a(1, 2, 3, 4), '0, b);
        send_beat(1'b0, 1'b1, pack_a(2, 4, 6, 8), '0, b);
        tick();
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out[31:0] !== 32'd10)
                begin errors++; $display("FAIL freeze_out: valid=%b out0=%0d, required 1/10", out_valid, out[31:0]); end
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL freeze_in_ready: got %b, required 0", in_ready); end
        end
        enable = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out[31:0] !== 32'd20)
            begin errors++; $display("FAIL freeze_resume: valid=%b out0=%0d, required 1/20", out_valid, out[31:0]); end
        drain();
    endtask

    task automatic test_overflow();
        logic [BW-1:0] b;
        b = '0;
        for (int k = 0; k < 4; k++) begin
            b = put_b(b, 0, k, -128);
            b = put_b(b, 1, k, 127);
            b = put_b(b, 2, k, 1);
        end
        for (int i = 0; i < 33100; i++)
            send_beat(1'b0, i == 33099, pack_a(-128, -128, -128, -128), '0, b);
        wait_valid();
`ifdef SP_DP_SATURATE_EN
        checks++;
        if (out[31:0] !== 32'h7FFFFFFF) begin errors++; $display("FAIL ovf_out0: got %h, required 7fffffff", out[31:0]); end
        checks++;
        if (out[63:32] !== 32'h80000000) begin errors++; $display("FAIL ovf_out1: got %h, required 80000000", out[63:32]); end
`else
        checks++;
        if (out[31:0] !== 32'h814C0000) begin errors++; $display("FAIL ovf_out0: got %h, required 814c0000", out[31:0]); end
        checks++;
        if (out[63:32] !== 32'h7FB69800) begin errors++; $display("FAIL ovf_out1: got %h, required 7fb69800", out[63:32]); end
`endif
        checks++;
        if (out_beats !== 8'hFF) begin errors++; $display("FAIL ovf_beats: got %0d, required 255", out_beats); end
        drain();
    endtask

    task automatic test_reset_mid_tile();
        logic [BW-1:0] b;
        b = '0;
        for (int k = 0; k < 4; k++) b = put_b(b, 0, k, 1);
        send_beat(1'b0, 1'b0, pack_a(1, 2, 3, 4), '0, b);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out !== '0 || out_valid !== 1'b0 || out_beats !== '0)
            begin errors++; $display("FAIL async_reset_out: out=%h valid=%b beats=%0d, required 0", out, out_valid, out_beats); end
        checks++;
        if (meta_err !== 1'b0) begin errors++; $display("FAIL async_reset_meta_err: got %b, required 0", meta_err); end
        exp_q.delete();
        m_first = 1'b1;
        m_err = 1'b0;
        tick();
        reset = 1'b1;
        send_beat(1'b0, 1'b1, pack_a(1, 2, 3, 4), 8'h4A, b);
        wait_valid();
        checks++;
        if (out[31:0] !== 32'd10 || out_beats !== 8'd1)
            begin errors++; $display("FAIL fresh_tile: out0=%0d beats=%0d, required 10/1", out[31:0], out_beats); end
        checks++;
        if (meta_err !== m_err) begin errors++; $display("FAIL dense_meta_ignored: got %b, required %b", meta_err, m_err); end
        drain();
    endtask

    initial begin
        test_reset();
        test_dense();
        test_sparse();
        test_bad_meta();
        test_backpressure();
        test_back_to_back();
        test_enable_freeze();
        test_overflow();
        test_reset_mid_tile();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sp_dp_group.md
Name: sp_dp_group

Overview:
- Next-generation dot-product group: one A vector broadcast to N_UNIT B vectors, as in the existing group.
- Adds 2:4 structured-sparse operand selection, a pipelined multiply/adder tree and multi-beat accumulation over a K tile.
- Adds valid/ready handshakes on input and output.
- Sits between the operand buffers and the tile writeback in the sparse tensor core.

Parameters:
- N_UNIT, 4, number of dot-product units (output channels).
- N_MUL, 4, multipliers per unit (nonzero A elements per beat).
- DW_MUL, 8, signed operand width.
- DW_ADD, 32, signed accumulator/output width.
- CNT_W, 8, beat-counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  global advance enable; 0 freezes the entire pipeline.
- mode  in  1  0 = dense, 1 = 2:4 sparse; sampled per accepted beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid&&in_ready.
- in_last  in  1  final beat of the K tile.
- in_a  in  N_MUL*DW_MUL  A values (compressed nonzeros in sparse mode).
- in_meta  in  N_MUL*2  per-A-element 2-bit position within its group of 4.
- in_b  in  N_UNIT*2*N_MUL*DW_MUL  dense B, 2*N_MUL elements per unit; unit u at slice u*2*N_MUL*DW_MUL.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid&&out_ready.
- out  out  N_UNIT*DW_ADD  per-unit accumulated sums; unit u at slice u*DW_ADD.
- out_beats  out  CNT_W  beats accumulated into this result; saturates at all-ones.
- meta_err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (async, reset==0): all pipeline valids, accumulators, out, out_beats, out_valid, meta_err go to 0. acc_first goes to 1. In-flight beats are dropped.
- Operand select, dense: element j of A pairs with B element j, for j<N_MUL.
- Operand select, sparse: element j of A pairs with B element 4*(j/2)+meta[j]. B element indices run 0..2*N_MUL-1.
- Products are signed DW_MUL x DW_MUL and sign-extended to DW_ADD before the tree.
- P1, at the accept edge t: register the products, last and mode.
- P2, at edge t+1: register the signed tree sum per unit.
- P3, at edge t+2:
  - acc <= acc_first ? sum : acc+sum; beat count updates the same way.
  - If last: load out/out_beats from the new value, set out_valid, set acc_first=1.
  - Otherwise clear acc_first.
  - Latency from accept of the last beat to out_valid is 3 cycles.
- Stall condition: stall = !enable || (out_valid && !out_ready && P2 holds a valid last beat).
- On stall, no pipeline register changes; in_ready = !stall.
- Bubbles advance normally. Non-last beats reaching P3 never stall.
- Output register:
  - out_valid clears on handshake unless a new result loads the same edge.
  - Load while out_valid&&out_ready is legal (back-to-back tiles, 1 result/cycle).
  - out holds stable while out_valid&&!out_ready.
- Overflow: default is two's-complement wrap in DW_ADD.
- meta_err sets on any accepted sparse beat where a pair (2k, 2k+1) has meta[2k] >= meta[2k+1]. The beat is still processed with the given indices.
- Dense beats ignore in_meta and never set meta_err.
- Mode may change between beats within a tile; each beat uses its own mode.
- in_last on a single-beat tile yields out = that beat's sum and out_beats = 1.

Optional Feature:
- Macro: SP_DP_SATURATE_EN.
- Defined: the accumulate add in P3 saturates to the DW_ADD signed max/min (0x7FFFFFFF / 0x80000000 at default width). The tree sum itself never overflows at defaults.
- Undefined: wrap-around.
- In both cases, out_valid timing is identical.

Test Plan:
- Dense single beat: a=[1,2,3,4]; unit0 b low=[1,1,1,1]; unit1 b low=[-1,0,0,2]; last=1 -> 3 cycles later out0=10, out1=7, out_beats=1.
- Sparse 2-beat tile:
  - Both beats: a=[5,-3,2,7], meta=[0,3,1,2].
  - Beat 1: unit0 b=0..7 -> sum = 5*0 + (-3)*3 + 2*5 + 7*6 = 43.
  - Beat 2: last=1 -> out0=86, out_beats=2, meta_err=0.
- Bad meta: sparse beat with meta pair [2,2] -> meta_err=1 and stays 1; the result is still produced. Reset clears it.
- Backpressure: three 1-beat tiles back-to-back with out_ready=0 -> in_ready drops once the second last beat is in P2; first result held stable. Then out_ready=1 -> all three results emerge in order, none lost.
- Back-to-back tiles with out_ready=1, in_valid continuous -> one result per cycle once the pipeline is full; enable=0 for 2 cycles mid-stream freezes out and valids.
- Overflow: accumulate 0x7F*0x7F*4 repeatedly past 2^31 -> wraps when SP_DP_SATURATE_EN is undefined; clamps at 0x7FFFFFFF when defined.
- Async reset asserted mid-tile -> outputs 0 immediately. The next tile's first beat starts a fresh accumulation.
